// File: rtl/uart_channel_selector.sv
// Break-before-make UART channel selector: decodes a one-hot channel command
// from the host bus and drives a one-hot enable with an all-off guard gap on switches.
module uart_channel_selector #(
  parameter int unsigned CHANNEL_AMOUNT = 8,
  parameter int unsigned BUS_WIDTH      = 16,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned GUARD_CYCLES   = 16,
  localparam int unsigned CH_W = (CHANNEL_AMOUNT > 1) ? $clog2(CHANNEL_AMOUNT) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic [BUS_WIDTH-1:0]      d_bus,
  input  logic                      latch_mode,
  output logic [CHANNEL_AMOUNT-1:0] uart_en,
  output logic [CH_W-1:0]           active_ch,
  output logic                      busy,
  output logic                      cmd_err
);

  localparam int unsigned CNT_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GUARD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] en_sync_q;
  logic [BUS_WIDTH-1:0]   d_sync_q [SYNC_STAGES];
  logic                   en_d_q;
  logic                   en_s;
  logic [BUS_WIDTH-1:0]   d_s;
  logic                   rise;
  logic                   fall;

  logic [CH_W-1:0]  sel_q, sel_d;
  logic [CH_W-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d;

  logic [CHANNEL_AMOUNT-1:0] uart_en_q, uart_en_d;
  logic [CH_W-1:0]           active_ch_q;
  logic                      busy_q;
  logic                      cmd_err_q;

  int unsigned     ones;
  logic            hi_bit;
  logic [CH_W-1:0] cmd_idx;
  logic            cmd_zero;
  logic            cmd_valid;

  assign en_s = en_sync_q[SYNC_STAGES-1];
  assign d_s  = d_sync_q[SYNC_STAGES-1];
  assign rise = en_s & ~en_d_q;
  assign fall = ~en_s & en_d_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      en_sync_q <= '0;
      en_d_q    <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) d_sync_q[i] <= '0;
    end else begin
      en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], en};
      en_d_q      <= en_s;
      d_sync_q[0] <= d_bus;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) d_sync_q[i] <= d_sync_q[i-1];
    end
  end

  // Valid means exactly one bit set and that bit addresses an existing channel.
  always_comb begin
    ones    = 0;
    hi_bit  = 1'b0;
    cmd_idx = '0;
    for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
      if (d_s[i]) begin
        ones = ones + 1;
        if (i < CHANNEL_AMOUNT) cmd_idx = CH_W'(i);
        else                    hi_bit  = 1'b1;
      end
    end
    cmd_zero  = (ones == 0);
    cmd_valid = (ones == 1) && !hi_bit;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (rise) begin
      if (cmd_zero) begin
        state_d = IDLE;
        pend_d  = '0;
        cnt_d   = '0;
      end else if (!cmd_valid) begin
        state_d = IDLE;
        pend_d  = '0;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_d = ACTIVE;
            sel_d   = cmd_idx;
          end
          ACTIVE: begin
            if (cmd_idx != sel_q) begin
              if (GUARD_CYCLES == 0) begin
                sel_d = cmd_idx;
              end else begin
                state_d = GUARD;
                pend_d  = cmd_idx;
                cnt_d   = CNT_W'(GUARD_CYCLES);
              end
            end
          end
          GUARD: begin
            pend_d = cmd_idx;
            cnt_d  = CNT_W'(GUARD_CYCLES);
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (fall && !latch_mode && state_q != IDLE) begin
      state_d = IDLE;
      pend_d  = '0;
      cnt_d   = '0;
    end else if (state_q == GUARD) begin
      if (cnt_q <= CNT_W'(1)) begin
        state_d = ACTIVE;
        sel_d   = pend_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  assign uart_en_d = (state_d == ACTIVE) ? (CHANNEL_AMOUNT'(1) << sel_d) : '0;

  // Outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      pend_q      <= '0;
      cnt_q       <= '0;
      uart_en_q   <= '0;
      active_ch_q <= '0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      uart_en_q   <= uart_en_d;
      active_ch_q <= (state_d == ACTIVE) ? sel_d : '0;
      busy_q      <= (state_d == GUARD);
      cmd_err_q   <= err_d;
    end
  end

  assign uart_en   = uart_en_q;
  assign active_ch = active_ch_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_channel_selector.sv
// Bench for uart_channel_selector: directed scenarios plus random commands,
// checked every cycle against a deadline-based model of the selector.
module tb_uart_channel_selector;

  localparam int unsigned CA = 8;
  localparam int unsigned BW = 16;
  localparam int unsigned SS = 2;
  localparam int unsigned GC = 16;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic [BW-1:0] d_bus = '0;
  logic          latch_mode = 1'b1;
  logic [CA-1:0] uart_en;
  logic [CW-1:0] active_ch;
  logic          busy;
  logic          cmd_err;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  uart_channel_selector #(
    .CHANNEL_AMOUNT(CA),
    .BUS_WIDTH(BW),
    .SYNC_STAGES(SS),
    .GUARD_CYCLES(GC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .d_bus(d_bus),
    .latch_mode(latch_mode),
    .uart_en(uart_en),
    .active_ch(active_ch),
    .busy(busy),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the input seen by the selector at edge n is the one sampled at edge n-SS.
  // A channel switch is a target channel with an absolute completion edge number.
  bit       en_h[$];
  logic [BW-1:0] d_h[$];
  int       now = 0;
  int       m_on = -1;
  int       m_tgt = -1;
  int       m_due = 0;
  bit       m_err = 1'b0;

  always @(posedge clk) begin
    now++;
    m_err = 1'b0;
    if (reset) begin
      en_h.delete();
      d_h.delete();
      for (int i = 0; i <= SS; i++) begin
        en_h.push_back(1'b0);
        d_h.push_back('0);
      end
      m_on  = -1;
      m_tgt = -1;
    end else begin
      bit rise, fall;
      logic [BW-1:0] cmd;
      int sz, c;
      en_h.push_back(en);
      d_h.push_back(d_bus);
      if (en_h.size() > SS + 2) begin
        void'(en_h.pop_front());
        void'(d_h.pop_front());
      end
      sz   = en_h.size();
      rise = en_h[sz-1-SS] && !en_h[sz-2-SS];
      fall = !en_h[sz-1-SS] && en_h[sz-2-SS];
      cmd  = d_h[sz-1-SS];
      c = -1;
      for (int i = 0; i < BW; i++) if (cmd[i]) c = i;
      if (rise) begin
        if (cmd == 0) begin
          m_on = -1; m_tgt = -1;
        end else if ($countones(cmd) != 1 || c >= CA) begin
          m_on = -1; m_tgt = -1; m_err = 1'b1;
        end else if (m_tgt >= 0) begin
          m_tgt = c; m_due = now + GC;
        end else if (m_on < 0) begin
          m_on = c;
        end else if (m_on != c) begin
          m_on = -1; m_tgt = c; m_due = now + GC;
        end
      end else if (fall && !latch_mode && (m_on >= 0 || m_tgt >= 0)) begin
        m_on = -1; m_tgt = -1;
      end else if (m_tgt >= 0 && now == m_due) begin
        m_on = m_tgt; m_tgt = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [CA-1:0] e_uart;
      e_uart = (m_on >= 0) ? CA'(1) << m_on : '0;
      check("uart_en", 32'(uart_en), 32'(e_uart));
      check("active_ch", 32'(active_ch), (m_on >= 0) ? 32'(m_on) : 32'd0);
      check("busy", 32'(busy), 32'(m_tgt >= 0));
      check("cmd_err", 32'(cmd_err), 32'(m_err));
      check("onehot", 32'($countones(uart_en) <= 1), 32'd1);
      if (busy) check("guard_off", 32'(uart_en), 32'd0);
    end
  end

  int            busy_cnt;
  int            err_cnt;
  logic [CA-1:0] seen;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (cmd_err) err_cnt++;
      seen |= uart_en;
    end
  endtask

  task automatic edges_until(input logic [CA-1:0] want, output int k);
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      if (uart_en == want) k = i;
    end
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_uart_en", 32'(uart_en), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Scenario 1: latched select of channel 2
    reset = 1'b0; latch_mode = 1'b1; en = 1'b1; d_bus = 16'h0004;
    step(2);
    check("s1_before", 32'(uart_en), 32'd0);
    step(1);
    check("s1_uart_en", 32'(uart_en), 32'h04);
    check("s1_active_ch", 32'(active_ch), 32'd2);
    en = 1'b0;
    step(10);
    check("s1_hold", 32'(uart_en), 32'h04);

    // Scenario 2: switch to channel 5 with guard
    busy_cnt = 0; seen = '0;
    en = 1'b1; d_bus = 16'h0020;
    step(40);
    check("s2_busy_len", 32'(busy_cnt), 32'd16);
    check("s2_uart_en", 32'(uart_en), 32'h20);
    check("s2_active_ch", 32'(active_ch), 32'd5);

    // Scenario 3: invalid commands
    en = 1'b0; step(4);
    err_cnt = 0;
    en = 1'b1; d_bus = 16'h0003; step(10);
    check("s3_err_0003", 32'(err_cnt), 32'd1);
    check("s3_off", 32'(uart_en), 32'd0);
    en = 1'b0; step(4);
    err_cnt = 0;
    en = 1'b1; d_bus = 16'h0100; step(10);
    check("s3_err_0100", 32'(err_cnt), 32'd1);
    check("s3_off2", 32'(uart_en), 32'd0);

    // Scenario 4: follow mode
    en = 1'b0; step(4);
    latch_mode = 1'b0;
    en = 1'b1; d_bus = 16'h0001;
    edges_until(8'h01, k);
    check("s4_on_latency", 32'(k), 32'd3);
    en = 1'b0;
    edges_until(8'h00, k);
    check("s4_off_latency", 32'(k), 32'd3);

    // Scenario 5: reloads during guard
    latch_mode = 1'b1;
    en = 1'b1; d_bus = 16'h0001; step(6);
    en = 1'b0; step(2);
    busy_cnt = 0; seen = '0;
    en = 1'b1; d_bus = 16'h0020; step(12);
    en = 1'b0; step(1);
    en = 1'b1; d_bus = 16'h0002; step(3);
    en = 1'b0; step(1);
    en = 1'b1; d_bus = 16'h0080; step(40);
    check("s5_busy_len", 32'(busy_cnt), 32'd33);
    check("s5_ch1_never", 32'(seen[1]), 32'd0);
    check("s5_uart_en", 32'(uart_en), 32'h80);

    // Scenario 6: reset mid-guard
    en = 1'b0; step(3);
    seen = '0;
    en = 1'b1; d_bus = 16'h0008; step(8);
    check("s6_in_guard", 32'(busy), 32'd1);
    reset = 1'b1; en = 1'b0; step(1);
    check("s6_rst_uart_en", 32'(uart_en), 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    check("s6_rst_active", 32'(active_ch), 32'd0);
    reset = 1'b0; step(25);
    check("s6_no_pending", 32'(seen[3]), 32'd0);
    en = 1'b1; d_bus = 16'h0040;
    edges_until(8'h40, k);
    check("s6_idle_latency", 32'(k), 32'd3);

    // Random phase
    for (int it = 0; it < 300; it++) begin
      int r;
      en = 1'b0;
      if ($urandom_range(0, 3) == 0) latch_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1; step(1); reset = 1'b0;
      end
      step($urandom_range(1, 20));
      r = $urandom_range(0, 9);
      if (r == 0)      d_bus = '0;
      else if (r <= 6) d_bus = BW'(1) << $urandom_range(0, CA - 1);
      else if (r == 7) d_bus = (BW'(1) << $urandom_range(0, 7)) | (BW'(1) << $urandom_range(8, 15));
      else if (r == 8) d_bus = BW'(1) << $urandom_range(CA, BW - 1);
      else             d_bus = BW'($urandom);
      en = 1'b1;
      step($urandom_range(1, 25));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
